// File: rtl/sobel_stream_core.sv
// sobel_stream_core: flow-controlled 3x3 Sobel edge-magnitude engine for
// raster-scan greyscale video. Three-stage pipeline (window, gradients,
// magnitude) under a single global stall driven by the output handshake.
// Optional feature: define SOBEL_THRESH_EN to add the thresh input and the
// registered out_edge flag (out_mag >= thresh).
module sobel_stream_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 64,
  parameter int unsigned MAG_WIDTH  = DATA_WIDTH + 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [MAG_WIDTH-1:0]  out_mag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
`ifdef SOBEL_THRESH_EN
  ,
  input  logic [MAG_WIDTH-1:0]  thresh,
  output logic                  out_edge
`endif
);

  localparam int unsigned SUM_W = DATA_WIDTH + 3;
  localparam int unsigned CMP_W = (SUM_W > MAG_WIDTH) ? SUM_W : MAG_WIDTH;
  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  logic                  stall;
  logic                  xfer;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [DATA_WIDTH-1:0] line1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] line2 [IMG_WIDTH];
  // win[column L/M/R][row T/M/B]; column 2 is the newest
  logic [DATA_WIDTH-1:0] win [3][3];
  logic                  a_valid, a_last;
  logic signed [SUM_W-1:0] gx_c, gy_c, gx_q, gy_q;
  logic                  b_valid, b_last;
  logic [SUM_W-1:0]      ax_c, ay_c, mag_c;
  logic [MAG_WIDTH-1:0]  sat_c;

  // Global stall: nothing moves while a result waits on the sink
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign xfer     = in_valid && in_ready;

  // 1*a + 2*b + 1*c for one Sobel tap line
  function automatic logic [SUM_W-1:0] wsum(input logic [DATA_WIDTH-1:0] a,
                                             input logic [DATA_WIDTH-1:0] b,
                                             input logic [DATA_WIDTH-1:0] c);
    return SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
  endfunction

  // Raster position of the pixel about to be accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (xfer) begin
      if (col == COL_W'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= (row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Line buffers: read-before-write shift of one line down per column
  always_ff @(posedge clk) begin
    if (xfer) begin
      line2[col] <= line1[col];
      line1[col] <= in_pixel;
    end
  end

  // 3x3 window plus stage-A valid/last; centre is (row-1, col-1)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
      a_valid <= 1'b0;
      a_last  <= 1'b0;
    end else if (!stall) begin
      if (xfer) begin
        win[0]    <= win[1];
        win[1]    <= win[2];
        win[2][0] <= line2[col];
        win[2][1] <= line1[col];
        win[2][2] <= in_pixel;
      end
      a_valid <= xfer && (row >= ROW_W'(2)) && (col >= COL_W'(2));
      a_last  <= xfer && (row == ROW_W'(IMG_HEIGHT - 1)) && (col == COL_W'(IMG_WIDTH - 1));
    end
  end

  // Signed gradients from the window
  always_comb begin
    gx_c = $signed(wsum(win[2][0], win[2][1], win[2][2]) - wsum(win[0][0], win[0][1], win[0][2]));
    gy_c = $signed(wsum(win[0][2], win[1][2], win[2][2]) - wsum(win[0][0], win[1][0], win[2][0]));
  end

  // Stage B: gradient registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx_q    <= '0;
      gy_q    <= '0;
      b_valid <= 1'b0;
      b_last  <= 1'b0;
    end else if (!stall) begin
      gx_q    <= gx_c;
      gy_q    <= gy_c;
      b_valid <= a_valid;
      b_last  <= a_last;
    end
  end

  // Magnitude |gx|+|gy| with saturation to the output width
  always_comb begin
    ax_c  = gx_q[SUM_W-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    ay_c  = gy_q[SUM_W-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag_c = ax_c + ay_c;
    sat_c = (CMP_W'(mag_c) > CMP_W'({MAG_WIDTH{1'b1}})) ? '1 : MAG_WIDTH'(mag_c);
  end

  // Stage C: registered outputs, held while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_last  <= 1'b0;
    end else if (!stall) begin
      out_valid <= b_valid;
      out_mag   <= sat_c;
      out_last  <= b_last;
    end
  end

`ifdef SOBEL_THRESH_EN
  // Threshold flag registered alongside out_mag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_edge <= 1'b0;
    end else if (!stall) begin
      out_edge <= b_valid && (sat_c >= thresh);
    end
  end
`endif

endmodule

// File: tb/tb_sobel_stream_core.sv
// Bench for sobel_stream_core: 8x8 frames, MAG_WIDTH=10, compared against a
// direct Sobel reference computed from the whole frame. Edge flag checks are
// active when SOBEL_THRESH_EN is defined.
module tb_sobel_stream_core;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 8;
  localparam int unsigned H  = 8;
  localparam int unsigned MW = 10;
  localparam int MAXMAG = (1 << MW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_pixel;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] out_mag;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [MW-1:0] thresh;
  logic          out_edge;

  sobel_stream_core #(
    .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_WIDTH(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .out_mag(out_mag), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
`ifdef SOBEL_THRESH_EN
    , .thresh(thresh), .out_edge(out_edge)
`endif
  );

`ifndef SOBEL_THRESH_EN
  assign out_edge = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int mag;
    bit last;
    int r;
    int c;
  } exp_t;

  exp_t expq[$];
  int   img [H][W];
  int   checks   = 0;
  int   failures = 0;
  int   ne       = 0;
  int   mode     = 0;  // 1: step image, 2: diagonal image, else none
  int   got;

  always @(posedge clk) ne <= ne + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: Sobel at every interior centre of img, in raster order
  function automatic void build_model();
    int gx, gy, m, wt;
    exp_t e;
    for (int r = 1; r <= int'(H) - 2; r++) begin
      for (int c = 1; c <= int'(W) - 2; c++) begin
        gx = 0;
        gy = 0;
        for (int i = 0; i < 3; i++) begin
          wt = (i == 1) ? 2 : 1;
          gx += wt * (img[r-1+i][c+1] - img[r-1+i][c-1]);
          gy += wt * (img[r+1][c-1+i] - img[r-1][c-1+i]);
        end
        m = iabs(gx) + iabs(gy);
        if (m > MAXMAG) m = MAXMAG;
        e.mag  = m;
        e.last = (r == int'(H) - 2) && (c == int'(W) - 2);
        e.r    = r;
        e.c    = c;
        expq.push_back(e);
      end
    end
  endfunction

  // Stream one frame; called and returns at posedge+1
  task automatic run_frame(input int stall_pct, input int gap_pct, input int abort_at,
                           input bit chk_lat, output int n_out);
    int idx = 0;
    int guard = 0;
    int lat_x = -1;
    int lat_v = -1;
    bit prev_stall = 1'b0;
    logic [MW-1:0] pm;
    logic pl, pe;
    exp_t e;
    n_out = 0;
    build_model();
    forever begin
      if (abort_at >= 0 && idx >= abort_at) begin
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_last", out_last, 0);
        chk("abort_out_mag", out_mag, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();
        return;
      end
      out_ready = ($urandom_range(99) >= stall_pct);
      if (idx < int'(W * H) && $urandom_range(99) >= gap_pct) begin
        in_valid = 1'b1;
        in_pixel = DW'(img[idx / W][idx % W]);
      end else begin
        in_valid = 1'b0;
        in_pixel = DW'($urandom);
      end
      #1;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_mag", out_mag, pm);
        chk("stall_last", out_last, pl);
        chk("stall_edge", out_edge, pe);
      end
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && lat_v < 0) lat_v = ne;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("spurious_result", out_valid, 0);
        end else begin
          e = expq.pop_front();
          chk("mag", out_mag, e.mag);
          chk("last", out_last, e.last);
`ifdef SOBEL_THRESH_EN
          chk("edge", out_edge, (e.mag >= int'(thresh)));
`endif
          if (mode == 1) chk("step_col", out_mag, (e.c == 3 || e.c == 4) ? 1020 : 0);
          if (mode == 2 && e.r == 3 && e.c == 4) chk("sat_3_4", out_mag, 1023);
          n_out++;
        end
      end
      prev_stall = out_valid && !out_ready;
      pm = out_mag;
      pl = out_last;
      pe = out_edge;
      if (in_valid && in_ready) begin
        if (idx == int'(2 * W + 2)) lat_x = ne;
        idx++;
      end
      @(posedge clk);
      #1;
      if (idx == int'(W * H) && expq.size() == 0) break;
      guard++;
      if (guard > 3000) begin
        chk("timeout", guard, 0);
        break;
      end
    end
    in_valid = 1'b0;
    if (abort_at < 0) chk("count", n_out, (W - 2) * (H - 2));
    // transfer edge is lat_x+1; out_valid must appear two edges later
    if (chk_lat) chk("latency", lat_v - (lat_x + 1), 2);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
    thresh    = MW'(1020);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_mag", out_mag, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_edge", out_edge, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Constant image: all zero magnitudes, latency check
    mode = 0;
    for (int r = 0; r < int'(H); r++) for (int c = 0; c < int'(W); c++) img[r][c] = 100;
    run_frame(0, 0, -1, 1'b1, got);

    // Vertical step, threshold 1020
    mode = 1;
    for (int r = 0; r < int'(H); r++) for (int c = 0; c < int'(W); c++) img[r][c] = (c < 4) ? 0 : 255;
    run_frame(0, 0, -1, 1'b0, got);

    // Diagonal image: saturation at centre (3,4)
    mode = 2;
    for (int r = 0; r < int'(H); r++) for (int c = 0; c < int'(W); c++) img[r][c] = (r + c >= 8) ? 255 : 0;
    run_frame(0, 0, -1, 1'b0, got);

    // Vertical step with stalls and input gaps, threshold 1021
    mode = 1;
    thresh = MW'(1021);
    for (int r = 0; r < int'(H); r++) for (int c = 0; c < int'(W); c++) img[r][c] = (c < 4) ? 0 : 255;
    run_frame(40, 30, -1, 1'b0, got);

    // Random images with stalls and gaps
    mode = 0;
    for (int k = 0; k < 3; k++) begin
      thresh = MW'($urandom_range(MAXMAG));
      for (int r = 0; r < int'(H); r++) for (int c = 0; c < int'(W); c++) img[r][c] = int'($urandom_range(255));
      run_frame(35, 25, -1, 1'b0, got);
    end

    // Abort mid-row 5, then a complete new frame
    for (int r = 0; r < int'(H); r++) for (int c = 0; c < int'(W); c++) img[r][c] = int'($urandom_range(255));
    run_frame(20, 10, int'(5 * W + 3), 1'b0, got);
    for (int r = 0; r < int'(H); r++) for (int c = 0; c < int'(W); c++) img[r][c] = int'($urandom_range(255));
    run_frame(20, 10, -1, 1'b0, got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
